// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with synchronous load (clamped), enable, tc flag and wrap pulse.
// Latency: count/wrap registered, update one cycle after the edge; tc is combinational from count/up.
// Backpressure: none; en gates stepping and count holds while en=0. Optional prescaler: CNT_PRESCALE_EN.
module mod_updown_counter #(
  parameter int WIDTH    = 4,   // counter width in bits, >= 1
  parameter int MODULUS  = 16,  // count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
  parameter int PRESCALE = 4    // enabled cycles per step when the prescaler is built, >= 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  // Terminal value; the extra compare bit lets MODULUS == 2**WIDTH be represented.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] step_count;
  logic             step_wrap;

  // Clamp out-of-range loads to the top of the range and compute the next step value.
  always_comb begin
    load_clamped = load_val;
    if ({1'b0, load_val} >= MOD_EXT) begin
      load_clamped = MAX_VAL;
    end
    step_count = count;
    step_wrap  = 1'b0;
    if (up) begin
      if (count == MAX_VAL) begin
        step_count = '0;
        step_wrap  = 1'b1;
      end else begin
        step_count = count + WIDTH'(1);
      end
    end else begin
      if (count == '0) begin
        step_count = MAX_VAL;
        step_wrap  = 1'b1;
      end else begin
        step_count = count - WIDTH'(1);
      end
    end
  end

`ifdef CNT_PRESCALE_EN
  // Prescaler only needs to reach PRESCALE-1; a 1-bit register covers PRESCALE=1.
  localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps;

  // All state: rst beats load beats en; a step happens only on the last prescaled enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
      ps    <= '0;
    end else if (load) begin
      count <= load_clamped;
      wrap  <= 1'b0;
      ps    <= '0;
    end else if (en) begin
      if (ps == PS_LAST) begin
        ps    <= '0;
        count <= step_count;
        wrap  <= step_wrap;
      end else begin
        ps    <= ps + PS_W'(1);
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end
`else
  // All state: rst beats load beats en; every enabled cycle is a step.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      wrap  <= 1'b0;
    end else if (en) begin
      count <= step_count;
      wrap  <= step_wrap;
    end else begin
      wrap <= 1'b0;
    end
  end
`endif

  // Terminal count depends on direction only, never on en.
  assign tc = up ? (count == MAX_VAL) : (count == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] count, count16;
  logic       tc, wrap, tc16, wrap16;

  int checks = 0;
  int errors = 0;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count), .tc(tc), .wrap(wrap)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(4)) dut16 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count16), .tc(tc16), .wrap(wrap16)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (count !== 4'd0 || wrap !== 1'b0 || tc !== 1'b0) begin
        errors++;
        $display("FAIL reset: count=%0d wrap=%0b tc=%0b expected count=0 wrap=0 tc=0", count, wrap, tc);
      end
    end
    up = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b1) begin
      errors++;
      $display("FAIL reset_tc_down: tc=%0b expected 1", tc);
    end
    up = 1'b1;
    rst = 1'b0;
  endtask

  task automatic test_count_up();
    int exp_c;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_c = i % 10;
      checks++;
      if (count !== 4'(exp_c) || wrap !== (i == 10) || tc !== (exp_c == 9)) begin
        errors++;
        $display("FAIL count_up step %0d: count=%0d wrap=%0b tc=%0b expected count=%0d wrap=%0b tc=%0b",
                 i, count, wrap, tc, exp_c, (i == 10), (exp_c == 9));
      end
    end
  endtask

  task automatic test_load_down();
    logic [3:0] exp_c [4];
    logic       exp_w [4];
    logic       exp_t [4];
    exp_c = '{4'd2, 4'd1, 4'd0, 4'd9};
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_t = '{1'b0, 1'b0, 1'b1, 1'b0};
    load = 1'b1; load_val = 4'd3; up = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (count !== 4'd3 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL load3: count=%0d wrap=%0b expected count=3 wrap=0", count, wrap);
    end
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (count !== exp_c[i] || wrap !== exp_w[i] || tc !== exp_t[i]) begin
        errors++;
        $display("FAIL count_down step %0d: count=%0d wrap=%0b tc=%0b expected count=%0d wrap=%0b tc=%0b",
                 i, count, wrap, tc, exp_c[i], exp_w[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_clamp_and_priority();
    load = 1'b1; load_val = 4'd12; en = 1'b1; up = 1'b1;
    tick();
    checks++;
    if (count !== 4'd9 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL clamp: count=%0d wrap=%0b expected count=9 wrap=0", count, wrap);
    end
    load_val = 4'd5;
    tick();
    checks++;
    if (count !== 4'd5 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_beats_en: count=%0d wrap=%0b expected count=5 wrap=0", count, wrap);
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_direction_hold_rst();
    load = 1'b1; load_val = 4'd0; up = 1'b1; en = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    checks++;
    if (count !== 4'd7) begin
      errors++;
      $display("FAIL up_to_7: count=%0d expected 7", count);
    end
    up = 1'b0;
    tick();
    tick();
    checks++;
    if (count !== 4'd5 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL dir_change: count=%0d wrap=%0b expected count=5 wrap=0", count, wrap);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count !== 4'd5 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL hold %0d: count=%0d wrap=%0b expected count=5 wrap=0", i, count, wrap);
      end
    end
    rst = 1'b1; load = 1'b1; load_val = 4'd4; en = 1'b1;
    tick();
    checks++;
    if (count !== 4'd0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL rst_beats_load: count=%0d wrap=%0b expected count=0 wrap=0", count, wrap);
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_full_range();
    load = 1'b1; load_val = 4'd15; up = 1'b1; en = 1'b1;
    tick();
    checks++;
    if (count16 !== 4'd15 || tc16 !== 1'b1 || count !== 4'd9) begin
      errors++;
      $display("FAIL load15: count16=%0d tc16=%0b count10=%0d expected 15 1 9", count16, tc16, count);
    end
    load = 1'b0;
    tick();
    checks++;
    if (count16 !== 4'd0 || wrap16 !== 1'b1) begin
      errors++;
      $display("FAIL m16_up_wrap: count16=%0d wrap16=%0b expected count16=0 wrap16=1", count16, wrap16);
    end
    up = 1'b0;
    tick();
    checks++;
    if (count16 !== 4'd15 || wrap16 !== 1'b1 || tc16 !== 1'b0) begin
      errors++;
      $display("FAIL m16_down_wrap: count16=%0d wrap16=%0b tc16=%0b expected 15 1 0", count16, wrap16, tc16);
    end
    tick();
    checks++;
    if (count16 !== 4'd14 || wrap16 !== 1'b0) begin
      errors++;
      $display("FAIL m16_wrap_pulse: count16=%0d wrap16=%0b expected count16=14 wrap16=0", count16, wrap16);
    end
    en = 1'b0; up = 1'b1;
  endtask

`ifdef CNT_PRESCALE_EN
  task automatic test_prescale();
    rst = 1'b1; en = 1'b0; up = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (count !== 4'(i / 4)) begin
        errors++;
        $display("FAIL prescale step %0d: count=%0d expected %0d", i, count, i / 4);
      end
    end
    // Two enabled, two idle, then two enabled cycles complete the next interval.
    tick(); tick();
    en = 1'b0;
    tick(); tick();
    en = 1'b1;
    tick();
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("FAIL prescale_gap_early: count=%0d expected 3", count);
    end
    tick();
    checks++;
    if (count !== 4'd4) begin
      errors++;
      $display("FAIL prescale_gap: count=%0d expected 4", count);
    end
    tick(); tick();
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL prescale_load_restart: count=%0d expected 0", count);
    end
    tick();
    checks++;
    if (count !== 4'd1) begin
      errors++;
      $display("FAIL prescale_after_load: count=%0d expected 1", count);
    end
    en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_load_down();
    test_clamp_and_priority();
    test_direction_hold_rst();
    test_full_range();
`ifdef CNT_PRESCALE_EN
    test_prescale();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
